// File: rtl/ej32_seq_arb_if.sv
// Control/writeback bus between the eJ32 decoder, its execution units (AU, BR, LS)
// and the phase sequencer / writeback arbiter ej32_seq_arb.
interface ej32_seq_arb_if #(
  parameter int DSZ = 32,
  parameter int ASZ = 17,
  parameter int NU  = 3
);
  logic [7:0]      code_i;
  logic            code_v;
  logic            hold_i;
  logic [NU-1:0]   t_x_i;
  logic [NU*DSZ-1:0] t_i;
  logic [NU-1:0]   psel_i;
  logic [NU*ASZ-1:0] p_i;
  logic [NU-1:0]   en_o;
  logic [2:0]      phase_o;
  logic [DSZ-1:0]  t_o;
  logic            t_we;
  logic [ASZ-1:0]  p_o;
  logic            p_we;
  logic            rdy_o;
  logic            done_o;
  logic            err_o;

  // Decoder and execution units drive requests; they observe the arbitrated results.
  modport master (
    output code_i, code_v, hold_i, t_x_i, t_i, psel_i, p_i,
    input  en_o, phase_o, t_o, t_we, p_o, p_we, rdy_o, done_o, err_o
  );

  modport slave (
    input  code_i, code_v, hold_i, t_x_i, t_i, psel_i, p_i,
    output en_o, phase_o, t_o, t_we, p_o, p_we, rdy_o, done_o, err_o
  );
endinterface

// File: rtl/ej32_seq_arb.sv
// eJ32 multi-cycle phase sequencer and TOS / IP writeback arbiter for units AU(0), BR(1), LS(2).
// Optional stall watchdog: define EJ32_SEQ_WDOG_EN to abort a sequence held for WDOG cycles.
package ej32_pkg;
  typedef logic [7:0] opcode_t;

  localparam opcode_t ILOAD         = 8'h15;
  localparam opcode_t ILOAD_0       = 8'h1a;
  localparam opcode_t ILOAD_3       = 8'h1d;
  localparam opcode_t IALOAD        = 8'h2e;
  localparam opcode_t BALOAD        = 8'h33;
  localparam opcode_t CALOAD        = 8'h34;
  localparam opcode_t SALOAD        = 8'h35;
  localparam opcode_t ISTORE        = 8'h36;
  localparam opcode_t ISTORE_0      = 8'h3b;
  localparam opcode_t ISTORE_1      = 8'h3c;
  localparam opcode_t ISTORE_3      = 8'h3e;
  localparam opcode_t IASTORE       = 8'h4f;
  localparam opcode_t BASTORE       = 8'h54;
  localparam opcode_t CASTORE       = 8'h55;
  localparam opcode_t SASTORE       = 8'h56;
  localparam opcode_t IFEQ          = 8'h99;
  localparam opcode_t IFLE          = 8'h9e;
  localparam opcode_t IF_ICMPEQ     = 8'h9f;
  localparam opcode_t IF_ICMPGT     = 8'ha3;
  localparam opcode_t GOTO          = 8'ha7;
  localparam opcode_t JSR           = 8'ha8;
  localparam opcode_t RET           = 8'ha9;
  localparam opcode_t JRETURN       = 8'hb1;
  localparam opcode_t INVOKEVIRTUAL = 8'hb6;
  localparam opcode_t DONEXT        = 8'hca;
  localparam opcode_t DUPR          = 8'hcb;
  localparam opcode_t POPR          = 8'hcc;
  localparam opcode_t PUSHR         = 8'hcd;
  localparam opcode_t GET           = 8'hd0;
  localparam opcode_t PUT           = 8'hd1;

  typedef enum logic [1:0] {U_AU = 2'd0, U_BR = 2'd1, U_LS = 2'd2} unit_t;

  typedef struct packed {
    unit_t      unit;
    logic [2:0] nph;
  } dec_t;

  function automatic dec_t decode(opcode_t c);
    dec_t d;
    d = '{unit: U_AU, nph: 3'd1};
    case (c) inside
      [IFEQ:IFLE], [IF_ICMPEQ:IF_ICMPGT], GOTO, INVOKEVIRTUAL, DONEXT:
        d = '{unit: U_BR, nph: 3'd2};
      JSR:
        d = '{unit: U_BR, nph: 3'd3};
      RET, JRETURN, ILOAD, [ILOAD_0:ILOAD_3], ISTORE_0, DUPR, POPR, PUSHR:
        d = '{unit: U_BR, nph: 3'd1};
      IALOAD, BALOAD, CALOAD, SALOAD, ISTORE, [ISTORE_1:ISTORE_3],
      IASTORE, BASTORE, CASTORE, SASTORE, GET, PUT:
        d = '{unit: U_LS, nph: 3'd1};
      default: ;
    endcase
    return d;
  endfunction
endpackage

module ej32_seq_arb
  import ej32_pkg::*;
#(
  parameter int DSZ  = 32,
  parameter int ASZ  = 17,
  parameter int NU   = 3,
  parameter int WDOG = 255
) (
  input  logic           clk,
  input  logic           rst,
  ej32_seq_arb_if.slave  bus
);
  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t     state;
  opcode_t    code_q;
  logic [2:0] phase_q;
  logic       err_q;
  dec_t       dec;
  logic       run, last, abort, done, rdy, err_set;
  logic [NU-1:0]  owner_oh;
  logic [DSZ-1:0] t_sel;
  logic [ASZ-1:0] p_sel;

  assign dec      = decode(code_q);
  assign run      = (state == S_RUN);
  assign owner_oh = run ? ({{(NU-1){1'b0}}, 1'b1} << dec.unit) : '0;
  assign last     = (phase_q == dec.nph - 3'd1);

`ifdef EJ32_SEQ_WDOG_EN
  logic [7:0] wdog_q;
  assign abort = run & bus.hold_i & (wdog_q == 8'(WDOG - 1));
`else
  logic unused_wdog;
  assign unused_wdog = ^8'(WDOG);
  assign abort = 1'b0;
`endif

  // A redirect ends the sequence on any phase; otherwise the final unheld phase does.
  assign done    = run & ~abort & ((last & ~bus.hold_i) | bus.p_we);
  assign rdy     = ~run | done;
  // owner_oh is zero while idle, so every requester then counts as a stray write.
  assign err_set = |((bus.t_x_i | bus.psel_i) & ~owner_oh);

  // NOTE: combinational blocks use blocking assignments with a default first, so
  // later loop iterations override earlier ones and no latch is inferred.
  always_comb begin
    t_sel = '0;
    p_sel = '0;
    for (int k = NU - 1; k >= 0; k--) begin
      if (bus.t_x_i[k])  t_sel = bus.t_i[k*DSZ +: DSZ];
      if (bus.psel_i[k]) p_sel = bus.p_i[k*ASZ +: ASZ];
    end
    for (int k = 0; k < NU; k++) begin
      if (bus.t_x_i[k] & owner_oh[k])  t_sel = bus.t_i[k*DSZ +: DSZ];
      if (bus.psel_i[k] & owner_oh[k]) p_sel = bus.p_i[k*ASZ +: ASZ];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; every register,
  // including the latched opcode, is cleared by the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      code_q  <= '0;
      phase_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (err_set) err_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.code_v) begin
            state   <= S_RUN;
            code_q  <= bus.code_i;
            phase_q <= '0;
          end
        end
        S_RUN: begin
          if (abort) begin
            state   <= S_IDLE;
            phase_q <= '0;
            err_q   <= 1'b1;
          end else if (done) begin
            phase_q <= '0;
            if (bus.code_v) code_q <= bus.code_i;
            else            state  <= S_IDLE;
          end else if (!bus.hold_i) begin
            phase_q <= phase_q + 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef EJ32_SEQ_WDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   wdog_q <= '0;
    else if (run & bus.hold_i & ~done & ~abort) wdog_q <= wdog_q + 8'd1;
    else                                       wdog_q <= '0;
  end
`endif

  assign bus.en_o    = owner_oh;
  assign bus.phase_o = phase_q;
  assign bus.t_o     = t_sel;
  assign bus.t_we    = |bus.t_x_i;
  assign bus.p_o     = p_sel;
  assign bus.p_we    = |bus.psel_i;
  assign bus.rdy_o   = rdy;
  assign bus.done_o  = done;
  assign bus.err_o   = err_q;
endmodule
